fadd_writeback: RTL and testbench
=================================

# fadd_writeback

Issue-side scoreboard and result-side writeback for the pipelined `fadd` unit. It accepts add requests from the decode stage and gates them with a per-register pending scoreboard. It forwards the accepted operands and tag (`flag`, 5-bit `add`) into `fadd`, and catches the tagged result `NSTAGE` cycles later. It writes the result into a 32 x 32 FP register file and clears the pending bit.

## Interface

- `NSTAGE`, 3: fixed latency of `fadd` in cycles, from operands to `y`/`flagout`/`addout`; must be ≥ 1.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: decode presents an add this cycle.
- `iss_src1`, `iss_src2` in 5: source register indices.
- `iss_dst` in 5: destination register index.
- `iss_stall` out 1: combinational; request not accepted this cycle, decode holds.
- `fa_x1`, `fa_x2` out 32: operands to `fadd` (combinational register-file reads, bypassed).
- `fa_flag` out 1: `iss_valid & ~iss_stall`.
- `fa_add` out 5: `iss_dst`.
- `fa_y` in 32: `fadd` result.
- `fa_flagout` in 1: result valid.
- `fa_addout` in 5: result destination.
- `busy` out 1: any pending bit set.
- `tag_err` out 1: sticky tag-mismatch flag (checker only).
- `tag_err_cnt` out 8: saturating mismatch count (checker only).

## Operation

- **State**
  - `regs[0:31]`, 32 bits each; all writable, no hardwired zero.
  - `pending[31:0]`.
  - Guard counter `quiet` (0..`NSTAGE`).
- **Writeback fire:** `wb = fa_flagout & (quiet == NSTAGE)`.
- **Bypass:** a register index `r` is ready when `~pending[r] | (wb & fa_addout == r)`.
- **Stall:** `iss_stall = iss_valid & ~(ready(src1) & ready(src2) & ready(dst))`. Including `dst` blocks WAW.
- **Operand reads:** `fa_x1` = `fa_y` when `wb & fa_addout == iss_src1`, else `regs[iss_src1]`. Same rule for `fa_x2` with `iss_src2`.
- **At each edge:**
  - If `wb`: `regs[fa_addout] <= fa_y` and clear `pending[fa_addout]`.
  - If `fa_flag`: set `pending[iss_dst]`.
  - Set and clear on the same index in the same cycle: set wins.
- **Writeback with pending bit clear:** a `wb` on an index whose pending bit is clear still writes. With the checker enabled this counts as a mismatch.
- **Reset guard:** `fadd` has no reset, so stale `flagout` may still emerge after reset.
  - `quiet` resets to 0 and increments each cycle up to `NSTAGE`.
  - While `quiet < NSTAGE`, `fa_flagout` is ignored.
  - While `quiet < NSTAGE`, `iss_stall = iss_valid`.

## Timing

- **Reset values:**
  - `regs` all 0, `pending` 0, `quiet` 0.
  - `busy` 0, `tag_err` 0, `tag_err_cnt` 0.
  - `fa_flag` 0 (stall forced during the guard window).
- **Issue:** accepted in cycle t. The result is presented in cycle t+`NSTAGE` and written at the end of that cycle.
- **Dependent add:** can be accepted in cycle t+`NSTAGE` via the bypass. The minimum back-to-back dependency distance is therefore `NSTAGE` cycles.
- **Throughput:** one independent add per cycle, no bubbles.
- **`busy`:** registered from `pending`. It falls in the cycle after the last writeback.
- **Reset mid-operation:** all in-flight work is discarded. The first issue is possible `NSTAGE` cycles after `rstn` rises.

## Configuration

- `FADD_WB_TAGCHECK_EN`: compiles in the shadow tag checker.
- **Defined:**
  - An `NSTAGE`-deep shift register holds {`fa_flag`, `fa_add`} for each cycle, cleared on reset.
  - Once `quiet == NSTAGE`, the checker compares the shadow output with {`fa_flagout`, `fa_addout`} every cycle. The address is compared only when the shadow flag is 1.
  - A mismatch sets `tag_err` (sticky until reset) and increments `tag_err_cnt`, which saturates at 255.
- **Undefined:** no shift register; `tag_err` and `tag_err_cnt` are tied to 0.

## Test plan

- **Basic writeback:** after reset, wait `NSTAGE`. Issue dst=1, src1=0, src2=0; model returns `fa_y`=0x40400000 with `addout`=1 after 3 cycles. Expect `pending[1]` set for 3 cycles, `regs[1]`=0x40400000, then `busy`=0.
- **RAW bypass:** issue dst=2, then immediately src1=2. Expect the second issue stalled for exactly 2 cycles and accepted in the writeback cycle with `fa_x1`=`fa_y`.
- **WAW, same-cycle set and clear:** issue dst=5 while the writeback to 5 fires. Expect no stall, `regs[5]` updated, `pending[5]`=1 afterwards.
- **Reset guard:** pulse `rstn` low while `fa_flagout`=1 is held. Expect no register writes and `iss_stall`=1 for 3 cycles after `rstn` rises.
- **Streaming:** 32 independent issues (dst=0..31) back-to-back. Expect zero stalls and all 32 writes in order 3 cycles later.
- **Checker (`FADD_WB_TAGCHECK_EN`):** model returns `addout`=7 for an issue to dst=6. Expect `tag_err`=1, `tag_err_cnt`=1, and `regs[7]` written.

Source files
------------

// File: rtl/fadd_writeback.sv
// Issue scoreboard + writeback for the NSTAGE-deep fadd pipe; combinational stall, same-cycle result bypass.
// Optional shadow tag checker compiled in with FADD_WB_TAGCHECK_EN.
module fadd_writeback #(
  parameter int NSTAGE = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iss_valid,
  input  logic [4:0]  iss_src1,
  input  logic [4:0]  iss_src2,
  input  logic [4:0]  iss_dst,
  output logic        iss_stall,
  output logic [31:0] fa_x1,
  output logic [31:0] fa_x2,
  output logic        fa_flag,
  output logic [4:0]  fa_add,
  input  logic [31:0] fa_y,
  input  logic        fa_flagout,
  input  logic [4:0]  fa_addout,
  output logic        busy,
  output logic        tag_err,
  output logic [7:0]  tag_err_cnt
);

  localparam int QW = (NSTAGE < 2) ? 1 : $clog2(NSTAGE + 1);

  logic [31:0]   regs_q [32];
  logic [31:0]   pending_q, pending_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          guard_done;
  logic          wb;
  logic [31:0]   wb_hit;
  logic [31:0]   rdy_mask;

  // fadd is not reset, so its outputs are untrusted until a full pipe depth has elapsed
  assign guard_done = (quiet_q == QW'(NSTAGE));
  assign wb         = fa_flagout & guard_done;
  assign wb_hit     = wb ? (32'd1 << fa_addout) : 32'd0;
  assign rdy_mask   = ~pending_q | wb_hit;

  assign iss_stall = iss_valid & ~(guard_done & rdy_mask[iss_src1] &
                                   rdy_mask[iss_src2] & rdy_mask[iss_dst]);
  assign fa_flag   = iss_valid & ~iss_stall;
  assign fa_add    = iss_dst;
  assign fa_x1     = wb_hit[iss_src1] ? fa_y : regs_q[iss_src1];
  assign fa_x2     = wb_hit[iss_src2] ? fa_y : regs_q[iss_src2];
  assign busy      = |pending_q;

  always_comb begin
    pending_d = pending_q & ~wb_hit;
    // set after clear so a reissue to the retiring register stays pending
    if (fa_flag) pending_d = pending_d | (32'd1 << iss_dst);
    quiet_d = guard_done ? quiet_q : quiet_q + QW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
      quiet_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      quiet_q   <= quiet_d;
      if (wb) regs_q[fa_addout] <= fa_y;
    end
  end

`ifdef FADD_WB_TAGCHECK_EN
  logic [NSTAGE-1:0][5:0] shadow_q;
  logic                   tag_err_q;
  logic [7:0]             tag_cnt_q;
  logic [5:0]             shadow_out;
  logic                   mismatch;

  assign shadow_out = shadow_q[NSTAGE-1];
  assign mismatch   = guard_done &
                      ((shadow_out[5] != fa_flagout) |
                       (shadow_out[5] & (shadow_out[4:0] != fa_addout)) |
                       (wb & ~pending_q[fa_addout]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q  <= '0;
      tag_err_q <= 1'b0;
      tag_cnt_q <= '0;
    end else begin
      shadow_q[0] <= {fa_flag, fa_add};
      for (int i = 1; i < NSTAGE; i++) shadow_q[i] <= shadow_q[i-1];
      if (mismatch) begin
        tag_err_q <= 1'b1;
        if (tag_cnt_q != 8'hFF) tag_cnt_q <= tag_cnt_q + 8'd1;
      end
    end
  end

  assign tag_err     = tag_err_q;
  assign tag_err_cnt = tag_cnt_q;
`else
  assign tag_err     = 1'b0;
  assign tag_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fadd_writeback.sv
// Directed bench for fadd_writeback: behavioural fadd pipe, issue scoreboard checked by a negedge monitor.
module tb_fadd_writeback;
  localparam int NSTAGE = 3;

  logic        clk, rstn;
  logic        iss_valid;
  logic [4:0]  iss_src1, iss_src2, iss_dst;
  logic        iss_stall;
  logic [31:0] fa_x1, fa_x2;
  logic        fa_flag;
  logic [4:0]  fa_add;
  logic [31:0] fa_y;
  logic        fa_flagout;
  logic [4:0]  fa_addout;
  logic        busy, tag_err;
  logic [7:0]  tag_err_cnt;

  fadd_writeback #(.NSTAGE(NSTAGE)) dut (
    .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_dst(iss_dst), .iss_stall(iss_stall),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_flag(fa_flag), .fa_add(fa_add),
    .fa_y(fa_y), .fa_flagout(fa_flagout), .fa_addout(fa_addout),
    .busy(busy), .tag_err(tag_err), .tag_err_cnt(tag_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fadd model: no reset; result value is chosen by the stimulus at issue time
  logic [31:0] y_next;
  logic        ovr_addr;
  logic        force_fo;
  logic [4:0]  force_ao;
  logic [31:0] force_y;
  logic [37:0] pipe [NSTAGE] = '{default: '0};

  always @(posedge clk) begin
    pipe[0] <= {fa_flag, (ovr_addr ? 5'd7 : fa_add), y_next};
    for (int i = 1; i < NSTAGE; i++) pipe[i] <= pipe[i-1];
  end

  assign fa_flagout = pipe[NSTAGE-1][37] | force_fo;
  assign fa_addout  = force_fo ? force_ao : pipe[NSTAGE-1][36:32];
  assign fa_y       = force_fo ? force_y  : pipe[NSTAGE-1][31:0];

  typedef struct {
    int          cyc;
    logic [4:0]  dst;
    logic [31:0] x1;
    logic [31:0] x2;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && fa_flag) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: dst %0d accepted at cycle %0d with nothing expected", fa_add, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_cycle", 32'(cyc), 32'(e.cyc));
        chk("issue_dst", {27'd0, fa_add}, {27'd0, e.dst});
        chk("issue_x1", fa_x1, e.x1);
        chk("issue_x2", fa_x2, e.x2);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iss_valid = 1'b0;
    repeat (n) align();
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [31:0] y, input int stall,
                       input logic [31:0] x1, input logic [31:0] x2);
    int k;
    exp_q.push_back('{cyc: cyc + stall, dst: d, x1: x1, x2: x2});
    iss_valid = 1'b1;
    iss_src1  = s1;
    iss_src2  = s2;
    iss_dst   = d;
    y_next    = y;
    k = 0;
    #1;
    while (iss_stall && k < 40) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: dst %0d still stalled after %0d cycles, expected %0d", d, k, stall);
    end
    align();
    iss_valid = 1'b0;
  endtask

  function automatic logic [31:0] old_val(input int i);
    case (i)
      1:       old_val = 32'h4040_0000;
      2:       old_val = 32'h4000_0000;
      3:       old_val = 32'h3F80_0000;
      4:       old_val = 32'h4080_0000;
      5:       old_val = 32'h40C0_0000;
      default: old_val = 32'h0;
    endcase
  endfunction

  initial begin
    rstn = 1'b0; iss_valid = 1'b0; iss_src1 = '0; iss_src2 = '0; iss_dst = '0;
    y_next = '0; ovr_addr = 1'b0; force_fo = 1'b0; force_ao = '0; force_y = '0;

    // reset state
    repeat (2) align();
    iss_valid = 1'b1;
    #1;
    chk("rst_stall", {31'd0, iss_stall}, 32'd1);
    chk("rst_fa_flag", {31'd0, fa_flag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tag_err", {31'd0, tag_err}, 32'd0);
    chk("rst_tag_cnt", {24'd0, tag_err_cnt}, 32'd0);
    iss_valid = 1'b0;
    align();
    rstn = 1'b1;
    idle(NSTAGE);

    // basic writeback, busy window, read back
    issue(5'd0, 5'd0, 5'd1, 32'h4040_0000, 0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("basic_busy", {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
    end
    align();
    issue(5'd1, 5'd0, 5'd3, 32'h3F80_0000, 0, 32'h4040_0000, 32'h0);
    idle(4);

    // RAW: dependent issue stalls two cycles, accepted on the bypass
    issue(5'd0, 5'd0, 5'd2, 32'h4000_0000, 0, 32'h0, 32'h0);
    issue(5'd2, 5'd0, 5'd4, 32'h4080_0000, 2, 32'h4000_0000, 32'h0);
    idle(4);

    // WAW: reissue to 5 in its writeback cycle, pending must survive
    issue(5'd0, 5'd0, 5'd5, 32'h40A0_0000, 0, 32'h0, 32'h0);
    idle(2);
    issue(5'd5, 5'd0, 5'd5, 32'h40C0_0000, 0, 32'h40A0_0000, 32'h0);
    @(negedge clk);
    chk("waw_busy", {31'd0, busy}, 32'd1);
    align();
    idle(4);

    // streaming: 32 independent issues, then 32 read-backs of the new values
    for (int i = 0; i < 32; i++)
      issue(5'(i), 5'(i), 5'(i), 32'h4100_0000 + i, 0, old_val(i), old_val(i));
    for (int i = 0; i < 32; i++)
      issue(5'(i), 5'(i), 5'(i), 32'h4200_0000 + i, 0, 32'h4100_0000 + i, 32'h4100_0000 + i);
    idle(5);

    // reset guard: stale flagout held across reset must not write or release the stall
    rstn = 1'b0;
    force_fo = 1'b1; force_ao = 5'd9; force_y = 32'hDEAD_BEEF;
    iss_valid = 1'b1; iss_src1 = 5'd9; iss_src2 = 5'd1; iss_dst = 5'd10;
    repeat (2) align();
    chk("guard_rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    for (int k = 0; k < NSTAGE; k++) begin
      #1;
      chk("guard_stall", {31'd0, iss_stall}, 32'd1);
      align();
    end
    force_fo = 1'b0;
    issue(5'd9, 5'd1, 5'd10, 32'h4110_0000, 0, 32'h0, 32'h0);
    idle(4);

    // misrouted result: issue to 6 comes back tagged 7
    chk("pre_tag_err", {31'd0, tag_err}, 32'd0);
    ovr_addr = 1'b1;
    issue(5'd0, 5'd0, 5'd6, 32'h4120_0000, 0, 32'h0, 32'h0);
    ovr_addr = 1'b0;
    idle(4);
`ifdef FADD_WB_TAGCHECK_EN
    chk("tag_err", {31'd0, tag_err}, 32'd1);
    chk("tag_err_cnt", {24'd0, tag_err_cnt}, 32'd1);
`else
    chk("tag_err", {31'd0, tag_err}, 32'd0);
    chk("tag_err_cnt", {24'd0, tag_err_cnt}, 32'd0);
`endif
    issue(5'd7, 5'd0, 5'd8, 32'h4130_0000, 0, 32'h4120_0000, 32'h0);
    idle(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
